// File: rtl/pwm_compare_if.sv
// Duty-configuration handshake between a duty source and pwm_compare.
// The master offers cfg_duty with cfg_valid; the slave answers with cfg_ready.
interface pwm_compare_if #(
    parameter int N = 8
);
    logic         cfg_valid;
    logic [N-1:0] cfg_duty;
    logic         cfg_ready;

    modport master (output cfg_valid, cfg_duty, input  cfg_ready);
    modport slave  (input  cfg_valid, cfg_duty, output cfg_ready);
endinterface

// File: rtl/pwm_compare.sv
// PWM comparator fed by a free-running counter; duty is shadowed and applied at wrap.
// Define PWM_DEADTIME_EN to insert DT cycles of dead time on both outputs after each edge.
module pwm_compare #(
    parameter int           N        = 8,
    parameter logic [N-1:0] DUTY_RST = '0,
    parameter int           DT       = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] count,
    pwm_compare_if.slave cfg,
    output logic         pwm,
    output logic         pwm_bar,
    output logic         wrap_pulse,
    output logic         match_pulse
);
    localparam logic [0:0] IDLE    = 1'b0;
    localparam logic [0:0] PENDING = 1'b1;

    if (DT < 1 || DT > 15) begin : g_dt_range
        $error("pwm_compare: DT must be in 1..15");
    end

    logic [0:0]   state;
    logic [N-1:0] prev_count;
    logic [N-1:0] active_duty;
    logic [N-1:0] pend_duty;
    logic [N-1:0] eff;
    logic         wrap_det;
    logic         raw;

    // Only a genuine max->0 step counts; any other jump to 0 is not a period boundary.
    assign wrap_det = (prev_count == {N{1'b1}}) && (count == '0);
    assign eff      = (state == PENDING && wrap_det) ? pend_duty : active_duty;
    assign raw      = (count < eff);

    assign cfg.cfg_ready = (state == IDLE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            active_duty <= DUTY_RST;
            pend_duty   <= '0;
            prev_count  <= '0;
            wrap_pulse  <= 1'b0;
            match_pulse <= 1'b0;
        end else begin
            prev_count  <= count;
            wrap_pulse  <= wrap_det;
            match_pulse <= (count == eff) && (count != prev_count);
            if (state == IDLE) begin
                // A transfer landing on a wrap cycle waits for the following wrap.
                if (cfg.cfg_valid) begin
                    pend_duty <= cfg.cfg_duty;
                    state     <= PENDING;
                end
            end else begin
                if (wrap_det) begin
                    active_duty <= pend_duty;
                    state       <= IDLE;
                end
            end
        end
    end

`ifdef PWM_DEADTIME_EN
    logic       raw_q;
    logic [3:0] dt_cnt;
    logic [3:0] dt_nxt;
    logic       dt_ok;

    // Counter restarts on the raw edge itself, so the edge cycle is already dead.
    always_comb begin
        dt_nxt = dt_cnt;
        if (raw != raw_q)
            dt_nxt = '0;
        else if (dt_cnt < 4'(DT))
            dt_nxt = dt_cnt + 4'd1;
    end
    assign dt_ok = (dt_nxt >= 4'(DT));

    always_ff @(posedge clk) begin
        if (rst) begin
            raw_q   <= 1'b0;
            dt_cnt  <= '0;
            pwm     <= 1'b0;
            pwm_bar <= 1'b0;
        end else begin
            raw_q   <= raw;
            dt_cnt  <= dt_nxt;
            pwm     <= raw & dt_ok;
            pwm_bar <= ~raw & dt_ok;
        end
    end
`else
    always_ff @(posedge clk) begin
        if (rst) begin
            pwm     <= 1'b0;
            pwm_bar <= 1'b0;
        end else begin
            pwm     <= raw;
            pwm_bar <= ~raw;
        end
    end
`endif
endmodule

// File: tb/tb_pwm_compare.sv
// Scoreboarded bench for pwm_compare: a cycle model predicts outputs per edge,
// plus per-period counts of pwm highs, wraps and matches.
module tb_pwm_compare;
    localparam int DT = 2;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] count;
    logic       pwm, pwm_bar, wrap_pulse, match_pulse;

    pwm_compare_if #(.N(8)) cif ();

    pwm_compare #(.N(8), .DUTY_RST(8'd0), .DT(DT)) dut (
        .clk         (clk),
        .rst         (rst),
        .count       (count),
        .cfg         (cif.slave),
        .pwm         (pwm),
        .pwm_bar     (pwm_bar),
        .wrap_pulse  (wrap_pulse),
        .match_pulse (match_pulse)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    // tb-side counter and spec model state
    logic [7:0] cnt;
    logic       t, crst;
    logic [7:0] m_prev, m_act, m_pend;
    logic       m_pst, m_rawq;
    int         m_dt;
    logic [4:0] exp_q[$];
    logic [4:0] obs;
    int obs_hi, obs_lo, obs_wrap, obs_match, obs_both;

    task automatic chk(input string tag, input int got, input int want);
        n_cmp++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s: got %0d (0x%0h) want %0d (0x%0h) at %0t", tag, got, got, want, want, $time);
        end
    endtask

    function automatic int ehi(input int h);
`ifdef PWM_DEADTIME_EN
        return (h == 0) ? 0 : h - DT;
`else
        return h;
`endif
    endfunction

    task automatic clr();
        obs_hi = 0; obs_lo = 0; obs_wrap = 0; obs_match = 0;
    endtask

    task automatic cyc();
        logic [4:0] e;
        logic [7:0] eff;
        logic       wrap, raw, mt, p, pb;
        if (rst) begin
            e = 5'b00001;
            m_prev = '0; m_act = '0; m_pend = '0; m_pst = 1'b0; m_rawq = 1'b0; m_dt = 0;
        end else begin
            wrap = (m_prev == 8'hff) && (count == 8'h00);
            eff  = (m_pst && wrap) ? m_pend : m_act;
            raw  = (count < eff);
            mt   = (count == eff) && (count != m_prev);
            p    = raw;
            pb   = !raw;
`ifdef PWM_DEADTIME_EN
            if (raw != m_rawq) m_dt = 0;
            else if (m_dt < DT) m_dt = m_dt + 1;
            m_rawq = raw;
            p  = raw && (m_dt >= DT);
            pb = !raw && (m_dt >= DT);
`endif
            if (m_pst) begin
                if (wrap) begin m_act = m_pend; m_pst = 1'b0; end
            end else if (cif.cfg_valid) begin
                m_pend = cif.cfg_duty; m_pst = 1'b1;
            end
            m_prev = count;
            e = {p, pb, wrap, mt, !m_pst};
        end
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        obs = {pwm, pwm_bar, wrap_pulse, match_pulse, cif.cfg_ready};
        chk("cycle", obs, exp_q.pop_front());
        obs_hi    += int'(pwm);
        obs_lo    += int'(!pwm);
        obs_wrap  += int'(wrap_pulse);
        obs_match += int'(match_pulse);
        obs_both  += int'(pwm & pwm_bar);
        if (crst) cnt = 8'h00;
        else if (t) cnt = cnt + 8'd1;
        count = cnt;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) cyc();
    endtask

    task automatic run_to(input logic [7:0] target);
        for (int i = 0; i < 300; i++) begin
            if (count == target) return;
            cyc();
        end
        chk("run_to_timeout", int'(count), int'(target));
    endtask

    task automatic offer(input logic [7:0] d);
        cif.cfg_valid = 1'b1;
        cif.cfg_duty  = d;
        cyc();
        cif.cfg_valid = 1'b0;
        cif.cfg_duty  = 8'hxx;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; t = 1'b1; crst = 1'b0; cnt = '0; count = '0;
        cif.cfg_valid = 1'b0; cif.cfg_duty = '0;
        obs_both = 0;
        clr();
        run(2);
        rst = 1'b0;

        // 1: reset mid-count
        run(50);
        rst = 1'b1;
        run(3);
        chk("rst_outputs", obs, 5'b00001);
        rst = 1'b0;
        run_to(8'd0);
        clr(); run(256);
        chk("rst_period_hi", obs_hi, 0);

        // 2: load 64 in IDLE
        run_to(8'd100);
        offer(8'd64);
        chk("t2_ready_lo", cif.cfg_ready, 0);
        run_to(8'd0);
        clr(); cyc();
        chk("t2_wrap", wrap_pulse, 1);
        chk("t2_ready_hi", cif.cfg_ready, 1);
        run(255);
        chk("t2_hi", obs_hi, ehi(64));
        chk("t2_match", obs_match, 1);
        chk("t2_wraps", obs_wrap, 1);

        // 3: accept on the wrap cycle -> applied one period later
        clr();
        offer(8'd200);
        chk("t3_ready_lo", cif.cfg_ready, 0);
        run(255);
        chk("t3_old_hi", obs_hi, ehi(64));
        clr(); run(256);
        chk("t3_new_hi", obs_hi, ehi(200));
        chk("t3_ready_hi", cif.cfg_ready, 1);

        // 4: offer while PENDING is ignored; frozen count
        run_to(8'd50);
        offer(8'd100);
        run_to(8'd60);
        offer(8'd10);
        chk("t4_ready_lo", cif.cfg_ready, 0);
        run_to(8'd0);
        clr(); run(256);
        chk("t4_hi", obs_hi, ehi(100));
        run_to(8'd30);
        t = 1'b0;
        clr(); run(20);
        chk("t4_frz_hi", obs_hi, 20);
        chk("t4_frz_wrap", obs_wrap, 0);
        chk("t4_frz_match", obs_match, 0);
        t = 1'b1;

        // 5: counter reset jump is not a wrap; duty 0 and duty 255 extremes
        run_to(8'd30);
        offer(8'd0);
        run_to(8'd37);
        crst = 1'b1; cyc(); crst = 1'b0;
        clr(); run(256);
        chk("t5_jump_wrap", obs_wrap, 0);
        chk("t5_jump_hi", obs_hi, 100);
        chk("t5_jump_pend", cif.cfg_ready, 0);
        clr(); run(256);
        chk("t5_d0_hi", obs_hi, 0);
        chk("t5_d0_wrap", obs_wrap, 1);
        chk("t5_d0_match", obs_match, 1);
        run_to(8'd10);
        offer(8'd255);
        run_to(8'd0);
        clr(); run(256);
`ifdef PWM_DEADTIME_EN
        chk("t5_d255_lo", obs_lo, 1 + DT);
`else
        chk("t5_d255_lo", obs_lo, 1);
`endif
        chk("never_both_high", obs_both, 0);
        chk("scoreboard_drained", exp_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
